// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns byte/half/word loads and stores into whole-word
// accesses on a word-organised data memory, using read-modify-write for SB/SH.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_store_data,
  output logic        resp_valid,
  output logic [31:0] resp_load_data,
  output logic        resp_fault,
  output logic        mem_enable,
  output logic        mem_write_enable,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 30;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    RMW_RD = 3'd2,
    RMW_WR = 3'd3,
    RESP   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          lane_q, lane_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                is_store_q, is_store_d;
  logic [15:0]         store_data_q, store_data_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_fault_q, resp_fault_d;
  logic [WORD_W-1:0]   resp_load_data_q, resp_load_data_d;
  logic                mem_enable_q, mem_enable_d;
  logic                mem_we_q, mem_we_d;
  logic [WORD_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]   mem_write_data_q, mem_write_data_d;
  logic                req_fault_c;

  // Select the addressed lane and sign/zero-extend it.
  function automatic logic [WORD_W-1:0] extend_load(input logic [WORD_W-1:0] word,
                                                    input logic [1:0] lane,
                                                    input logic [2:0] f3);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [WORD_W-1:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h0, b};
      3'b101:  r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] merge_word(input logic [WORD_W-1:0] old,
                                                   input logic [15:0] sd,
                                                   input logic [1:0] lane,
                                                   input logic is_half);
    logic [WORD_W-1:0] w;
    w = old;
    if (is_half) begin
      if (lane[1]) w[31:16] = sd;
      else         w[15:0]  = sd;
    end else begin
      case (lane)
        2'd0:    w[7:0]   = sd[7:0];
        2'd1:    w[15:8]  = sd[7:0];
        2'd2:    w[23:16] = sd[7:0];
        default: w[31:24] = sd[7:0];
      endcase
    end
    return w;
  endfunction

  // Legality, alignment and range check of the incoming request.
  always_comb begin
    logic legal;
    logic misaligned;
    logic out_of_range;
    legal      = 1'b0;
    misaligned = 1'b0;
    case (req_funct3)
      3'b000: legal = 1'b1;
      3'b001: begin legal = 1'b1;           misaligned = req_addr[0];    end
      3'b010: begin legal = 1'b1;           misaligned = |req_addr[1:0]; end
      3'b100: legal = !req_is_store;
      3'b101: begin legal = !req_is_store; misaligned = req_addr[0];    end
      default: legal = 1'b0;
    endcase
    out_of_range = req_addr[31:2] >= IDX_W'(MEM_WORDS);
    req_fault_c  = !legal || misaligned || out_of_range;
  end

  always_comb begin
    state_d          = state_q;
    lane_d           = lane_q;
    funct3_d         = funct3_q;
    is_store_d       = is_store_q;
    store_data_d     = store_data_q;
    resp_fault_d     = resp_fault_q;
    resp_load_data_d = resp_load_data_q;
    mem_addr_d       = mem_addr_q;
    mem_write_data_d = mem_write_data_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          lane_d       = req_addr[1:0];
          funct3_d     = req_funct3;
          is_store_d   = req_is_store;
          store_data_d = req_store_data[15:0];
          if (req_fault_c) begin
            state_d          = RESP;
            resp_fault_d     = 1'b1;
            resp_load_data_d = '0;
          end else begin
            mem_addr_d = {2'b00, req_addr[31:2]};
            if (!req_is_store) begin
              state_d = ACCESS;
            end else if (req_funct3 == 3'b010) begin
              state_d          = ACCESS;
              mem_write_data_d = req_store_data;
            end else begin
              state_d = RMW_RD;
            end
          end
        end
      end
      ACCESS: begin
        state_d          = RESP;
        resp_fault_d     = 1'b0;
        resp_load_data_d = is_store_q ? '0 : extend_load(mem_read_data, lane_q, funct3_q);
      end
      RMW_RD: begin
        state_d          = RMW_WR;
        mem_write_data_d = merge_word(mem_read_data, store_data_q, lane_q, funct3_q[0]);
      end
      RMW_WR: begin
        state_d          = RESP;
        resp_fault_d     = 1'b0;
        resp_load_data_d = '0;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Control outputs are a registered decode of the next state.
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    mem_enable_d = (state_d == ACCESS) || (state_d == RMW_RD) || (state_d == RMW_WR);
    mem_we_d     = ((state_d == ACCESS) && is_store_d) || (state_d == RMW_WR);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      lane_q           <= '0;
      funct3_q         <= '0;
      is_store_q       <= 1'b0;
      store_data_q     <= '0;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      resp_fault_q     <= 1'b0;
      resp_load_data_q <= '0;
      mem_enable_q     <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= '0;
      mem_write_data_q <= '0;
    end else begin
      state_q          <= state_d;
      lane_q           <= lane_d;
      funct3_q         <= funct3_d;
      is_store_q       <= is_store_d;
      store_data_q     <= store_data_d;
      req_ready_q      <= req_ready_d;
      resp_valid_q     <= resp_valid_d;
      resp_fault_q     <= resp_fault_d;
      resp_load_data_q <= resp_load_data_d;
      mem_enable_q     <= mem_enable_d;
      mem_we_q         <= mem_we_d;
      mem_addr_q       <= mem_addr_d;
      mem_write_data_q <= mem_write_data_d;
    end
  end

  assign req_ready        = req_ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_fault       = resp_fault_q;
  assign resp_load_data   = resp_load_data_q;
  assign mem_enable       = mem_enable_q;
  // The write strobe is gated by reset so an aborted RMW can never corrupt memory.
  assign mem_write_enable = mem_we_q && reset_n;
  assign mem_addr         = mem_addr_q;
  assign mem_write_data   = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a reference memory model predicts every
// response, memory side effects and latency, compared as responses appear.
module tb_load_store_unit;
  localparam int unsigned MEM_WORDS = 200;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_store_data;
  logic        resp_valid;
  logic [31:0] resp_load_data;
  logic        resp_fault;
  logic        mem_enable;
  logic        mem_write_enable;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_store_data(req_store_data),
    .resp_valid(resp_valid), .resp_load_data(resp_load_data), .resp_fault(resp_fault),
    .mem_enable(mem_enable), .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory seen by the DUT, plus an independent reference copy.
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic        addr_ok;
  assign addr_ok       = mem_addr < 32'(MEM_WORDS);
  assign mem_read_data = addr_ok ? mem[mem_addr[7:0]] : 32'h0;

  always @(posedge clk)
    if (mem_enable && mem_write_enable && addr_ok) mem[mem_addr[7:0]] <= mem_write_data;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          lat;
    int          en;
    int          we;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   en_cnt = 0;
  int   we_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Response monitor: pops the scoreboard on every resp_valid pulse.
  always @(negedge clk) begin
    if (mem_enable) en_cnt++;
    if (mem_write_enable) we_cnt++;
    if (resp_valid) begin
      if (sb.size() == 0) begin
        check("spurious_resp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("load_data", resp_load_data, mon_e.data);
        check("fault", 32'(resp_fault), 32'(mon_e.fault));
        check("latency", 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
        check("mem_en_cycles", 32'(en_cnt), 32'(mon_e.en));
        check("we_cycles", 32'(we_cnt), 32'(mon_e.we));
      end
      en_cnt = 0;
      we_cnt = 0;
    end
  end

  // Reference model of one request; updates ref_mem for stores when upd is set.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input bit upd, output exp_t e);
    logic        flt;
    logic [31:0] word, w, mask, nw;
    int          idx;
    int          sh;
    flt = 1'b0;
    case (f3)
      3'b000: flt = 1'b0;
      3'b001: flt = a[0];
      3'b010: flt = (a[1:0] != 2'b00);
      3'b100: flt = st;
      3'b101: flt = st || a[0];
      default: flt = 1'b1;
    endcase
    if ((a >> 2) >= 32'(MEM_WORDS)) flt = 1'b1;
    e.acc = 0;
    e.fault = flt;
    e.data = 32'h0;
    if (flt) begin
      e.lat = 1; e.en = 0; e.we = 0;
    end else begin
      idx  = int'(a >> 2);
      sh   = 8 * int'(a[1:0]);
      word = ref_mem[idx];
      if (!st) begin
        w = word >> sh;
        case (f3)
          3'b000:  e.data = {{24{w[7]}}, w[7:0]};
          3'b001:  e.data = {{16{w[15]}}, w[15:0]};
          3'b100:  e.data = {24'h0, w[7:0]};
          3'b101:  e.data = {16'h0, w[15:0]};
          default: e.data = word;
        endcase
        e.lat = 2; e.en = 1; e.we = 0;
      end else begin
        if (f3 == 3'b010) begin
          nw = d;
          e.lat = 2; e.en = 1; e.we = 1;
        end else begin
          mask = ((f3 == 3'b000) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
          nw = (word & ~mask) | ((d << sh) & mask);
          e.lat = 3; e.en = 2; e.we = 1;
        end
        if (upd) ref_mem[idx] = nw;
      end
    end
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input bit track);
    exp_t e;
    int   guard;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_store_data = d;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    model(st, f3, a, d, track, e);
    @(posedge clk);
    #1;
    e.acc = cyc;
    if (track) sb.push_back(e);
    @(negedge clk);
    check("busy_not_ready", 32'(req_ready), 32'd0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = 32'h0;
    reset_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_store_data = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_fault", 32'(resp_fault), 32'd0);
    check("rst_load_data", resp_load_data, 32'h0);
    check("rst_mem_enable", 32'(mem_enable), 32'd0);
    check("rst_mem_we", 32'(mem_write_enable), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_write_data, 32'h0);
    reset_n = 1'b1;

    // Word store then load back.
    issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b1);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    drain();
    check("sw_mem_word4", mem[4], 32'hDEAD_BEEF);

    // Byte store via read-modify-write.
    issue(1'b1, 3'b000, 32'h11, 32'h0000_0055, 1'b1);
    drain();
    check("sb_mem_word4", mem[4], 32'hDEAD_55EF);

    // Sub-word loads with sign and zero extension.
    issue(1'b1, 3'b010, 32'h10, 32'h80FF_7F01, 1'b1);
    issue(1'b0, 3'b000, 32'h13, 32'h0, 1'b1);
    issue(1'b0, 3'b100, 32'h13, 32'h0, 1'b1);
    issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b1);
    issue(1'b0, 3'b101, 32'h10, 32'h0, 1'b1);
    drain();

    // Faults: misaligned, out of range, illegal funct3.
    issue(1'b0, 3'b010, 32'h12, 32'h0, 1'b1);
    issue(1'b1, 3'b001, 32'h11, 32'hFFFF_FFFF, 1'b1);
    issue(1'b0, 3'b000, 32'(4 * MEM_WORDS), 32'h0, 1'b1);
    issue(1'b0, 3'b011, 32'h0, 32'h0, 1'b1);
    issue(1'b1, 3'b100, 32'h10, 32'h1234_5678, 1'b1);
    drain();
    check("fault_mem_word4", mem[4], 32'h80FF_7F01);

    // Reset during RMW_RD of an SH aborts it cleanly.
    issue(1'b1, 3'b001, 32'h12, 32'h0000_A5A5, 1'b0);
    check("rmw_rd_enable", 32'(mem_enable), 32'd1);
    reset_n = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_mem_en", 32'(mem_enable), 32'd0);
    check("abort_resp", 32'(resp_valid), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_mem_word4", mem[4], ref_mem[4]);

    // Reset arriving during RMW_WR must suppress the write strobe at once.
    issue(1'b1, 3'b000, 32'h10, 32'h0000_0033, 1'b0);
    req_valid = 1'b0;
    @(negedge clk);
    check("rmw_wr_we", 32'(mem_write_enable), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_forces_we", 32'(mem_write_enable), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort2_mem_word4", mem[4], ref_mem[4]);
    en_cnt = 0;
    we_cnt = 0;

    // Three requests held back-to-back on req_valid.
    issue(1'b1, 3'b001, 32'h22, 32'h0000_1234, 1'b1);
    issue(1'b0, 3'b001, 32'h22, 32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b1);
    drain();

    // Randomised traffic over a small window of words.
    for (int w = 0; w < 8; w++) issue(1'b1, 3'b010, 32'(4 * w), $urandom, 1'b1);
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? 32'(4 * MEM_WORDS) + 32'($urandom_range(0, 7))
                                      : 32'($urandom_range(0, 31));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1'b1);
    end
    drain();
    for (int w = 0; w < 8; w++) check("final_mem", mem[w], ref_mem[w]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Core-side initiator for the word-organised data memory.
- Accepts one load/store request at a time from the execute stage and translates RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into word-wide memory accesses.
- Sub-word stores use read-modify-write, because the memory has only a whole-word write enable.
- Returns the sign/zero-extended load result and flags misaligned or out-of-range accesses.

Parameters:
MEM_WORDS, 200, number of 32-bit words in the data memory; valid word index range 0..MEM_WORDS-1.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  synchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request this cycle
req_is_store  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  input  32  byte address
req_store_data  input  32  store operand (rs2)
resp_valid  output  1  one-cycle pulse: request complete
resp_load_data  output  32  extended load result, valid with resp_valid
resp_fault  output  1  misaligned/illegal/out-of-range, valid with resp_valid
mem_enable  output  1  memory access enable
mem_write_enable  output  1  memory word write strobe
mem_addr  output  32  word index = byte address >> 2
mem_write_data  output  32  word to write
mem_read_data  input  32  combinational read of word at mem_addr

Behaviour:
- States: IDLE, ACCESS, RMW_RD, RMW_WR, RESP. Reset (reset_n=0 at rising edge) forces IDLE from any state, including mid-RMW.
- Reset values: req_ready=1, resp_valid=0, resp_fault=0, resp_load_data=0, mem_enable=0, mem_write_enable=0, mem_addr=0, mem_write_data=0.
- mem_write_enable is combinationally forced to 0 while reset_n=0.
- req_ready=1 only in IDLE. A request is accepted at an edge where req_valid & req_ready; addr, funct3, is_store and store_data are latched at that edge.
- Fault checks are applied at acceptance:
  - H/HU/SH with addr[0]!=0 -> fault.
  - W/SW with addr[1:0]!=0 -> fault.
  - funct3 not in the legal set (stores allow only 000/001/010) -> fault.
  - addr[31:2] >= MEM_WORDS -> fault.
  - A faulting request goes directly IDLE->RESP with resp_fault=1 and resp_load_data=0. There is no memory activity: mem_enable and mem_write_enable stay 0.
- Load: IDLE->ACCESS.
  - ACCESS drives mem_enable=1 and mem_addr=addr[31:2]; mem_read_data is captured at the end of the cycle.
  - Byte lane = addr[1:0], half lane = addr[1].
  - B/H sign-extend; BU/HU zero-extend.
  - Then ->RESP.
- SW: IDLE->ACCESS with mem_enable=1, mem_write_enable=1, mem_write_data=store_data, then ->RESP.
- SB/SH:
  - IDLE->RMW_RD: mem_enable=1, write_enable=0; the old word is captured.
  - ->RMW_WR: write_enable=1; write data = old word with the target byte/half replaced by store_data[7:0]/[15:0] in lane addr[1:0]/addr[1]. Other bits are unchanged.
  - Then ->RESP.
- RESP: resp_valid=1 for exactly one cycle, then ->IDLE. There is no response backpressure.
  - resp_load_data holds its value until the next RESP.
  - For stores, resp_load_data=0.
- Latency from acceptance edge to resp_valid:
  - Fault: 1 cycle.
  - Load/SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Back-to-back throughput: one request per (latency+1) cycles. A new request can be accepted in the IDLE cycle following RESP.
- mem_write_enable is asserted for exactly one cycle per successful store and never during a load or fault.
- A request presented while not ready is ignored; the source holds it until accepted.

Test Plan:
- SW addr=0x10, data=0xDEADBEEF, then LW addr=0x10 -> mem word 4 = 0xDEADBEEF; LW resp_load_data=0xDEADBEEF, resp_fault=0, resp 2 cycles after acceptance.
- Word 4=0xDEADBEEF; SB addr=0x11, data=0x55 -> word 4=0xDEAD55EF; write_enable high exactly 1 cycle; resp 3 cycles after acceptance.
- Word 4=0x80FF7F01: LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x12 -> 0xFFFF80FF; LHU 0x10 -> 0x00007F01.
- LW addr=0x12, SH addr=0x11, LB addr=4*MEM_WORDS, funct3=011 load -> each resp_fault=1 after 1 cycle, load_data=0, mem_enable never asserted.
- Assert reset_n=0 during RMW_RD of an SH -> next cycle IDLE, req_ready=1, memory word unchanged, no resp_valid pulse.
- req_valid held high with three queued requests -> req_ready low while busy; each accepted only in IDLE; exactly three resp_valid pulses in order.
